// File: rtl/uart_payload_pkg.sv
// Shared types and constants for the UART payload collector.
// Imported by the collector RTL and its interface.
package uart_payload_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [7:0] PAD_DEFAULT = 8'h00;

endpackage

// File: rtl/uart_payload_collector_if.sv
// Byte-in / frame-out bundle around the collector.
// master drives the receiver side, slave is the collector.
interface uart_payload_collector_if #(
  parameter int DATA_BYTES = 8
);

  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    tx_ready;
  logic [8*DATA_BYTES-1:0] data;
  logic                    send;
  logic                    pending;
  logic                    dropped;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  data, send, pending, dropped
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output data, send, pending, dropped
  );

endinterface

// File: rtl/uart_payload_collector.sv
// Packs UART bytes into fixed-size frames for a UDP transmitter.
// Partial frames are padded and flushed after an idle timeout.
module uart_payload_collector
  import uart_payload_pkg::*;
#(
  parameter int         DATA_BYTES   = 8,
  parameter int         IDLE_TIMEOUT = 100000,
  parameter logic [7:0] PAD_BYTE     = PAD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    tx_ready,
  output logic [8*DATA_BYTES-1:0] data,
  output logic                    send,
  output logic                    pending,
  output logic                    dropped
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam int TW = (IDLE_TIMEOUT > 0) ?
                      $clog2(IDLE_TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] LAST_LANE = CW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] T_MAX     = TW'(IDLE_TIMEOUT);
  localparam logic [TW-1:0] T_LAST    =
    TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  fill;
  logic [CW-1:0] count;
  logic [CW-1:0] wr_lane;
  logic [TW-1:0] timer;
  logic          ack_wait;
  logic          accept;
  logic          flush;
  logic          xfer;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    flush    = 1'b0;
    xfer     = 1'b0;
    dropped  = 1'b0;
    wr_lane  = count;
    unique case (state)
      FILL: begin
        accept = rx_valid;
        flush  = (IDLE_TIMEOUT > 0) && (count != '0) &&
                 !rx_valid && (timer == T_LAST);
        if ((accept && count == LAST_LANE) || flush)
          state_nx = PEND;
      end
      PEND: begin
        xfer    = tx_ready && !ack_wait;
        accept  = xfer && rx_valid;
        dropped = rx_valid && !xfer;
        wr_lane = '0;
        // a one-byte frame can be completed by the coincident byte
        if (xfer)
          state_nx = (accept && DATA_BYTES == 1) ? PEND : FILL;
      end
      default: state_nx = FILL;
    endcase
    pending = (state == PEND);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill     <= '0;
      count    <= '0;
      timer    <= '0;
      ack_wait <= 1'b0;
      data     <= '0;
      send     <= 1'b0;
    end else begin
      send <= xfer;
      if (xfer) data <= fill;

      if (!tx_ready)  ack_wait <= 1'b0;
      else if (xfer)  ack_wait <= 1'b1;

      if (rx_valid || xfer)  timer <= '0;
      else if (timer != T_MAX) timer <= timer + TW'(1);

      if (xfer)        count <= accept ? CW'(1) : '0;
      else if (accept) count <= count + CW'(1);

      for (int i = 0; i < DATA_BYTES; i++) begin
        if (flush && CW'(i) >= count)
          fill[W-1-8*i -: 8] <= PAD_BYTE;
        if (accept && CW'(i) == wr_lane)
          fill[W-1-8*i -: 8] <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_payload_collector.sv
// Scoreboard bench: frames queued on completion, compared on send.
// Covers full, flush, backpressure, ack, coincident byte, reset.
module tb_uart_payload_collector;

  localparam int DB = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_payload_collector_if #(.DATA_BYTES(DB)) bus ();

  uart_payload_collector #(
    .DATA_BYTES  (DB),
    .IDLE_TIMEOUT(TO),
    .PAD_BYTE    (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rx_data (bus.rx_data),
    .rx_valid(bus.rx_valid),
    .tx_ready(bus.tx_ready),
    .data    (bus.data),
    .send    (bus.send),
    .pending (bus.pending),
    .dropped (bus.dropped)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sends = 0;
  int drops = 0;
  int send_cyc = 0;
  int t0, d0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] seq(input logic [7:0] b0);
    logic [63:0] r = '0;
    for (int i = 0; i < DB; i++)
      r = {r[55:0], 8'(b0 + 8'(i))};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.dropped) drops++;
    if (bus.send) begin
      sends++;
      send_cyc = cyc;
      if (exp_q.size() == 0)
        check("spurious_send", {63'b0, bus.send}, 64'd0);
      else
        check("frame", bus.data, exp_q.pop_front());
    end
  end

  task automatic put_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic put_frame(input logic [7:0] b0);
    for (int i = 0; i < DB; i++) put_byte(8'(b0 + 8'(i)));
  endtask

  task automatic toggle_ready();
    bus.tx_ready = 1'b0;
    idle(1);
    bus.tx_ready = 1'b1;
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    idle(3);
    check("rst_data", bus.data, 64'd0);
    check("rst_send", 64'(bus.send), 64'd0);
    check("rst_pending", 64'(bus.pending), 64'd0);
    check("rst_dropped", 64'(bus.dropped), 64'd0);
    reset_n = 1'b1;

    // full frame, latency from last byte
    for (int i = 1; i < DB; i++) put_byte(8'(i));
    t0 = cyc;
    exp_q.push_back(64'h0102030405060708);
    put_byte(8'h08);
    idle(5);
    check("full_latency", 64'(send_cyc - t0), 64'd2);
    check("full_sends", 64'(sends), 64'd1);

    // idle-timeout flush
    toggle_ready();
    put_byte(8'hAA);
    t0 = cyc;
    exp_q.push_back(64'hAABB000000000000);
    put_byte(8'hBB);
    idle(12);
    check("flush_early", 64'(sends), 64'd1);
    idle(13);
    check("flush_latency", 64'(send_cyc - t0), 64'(TO + 2));
    check("flush_sends", 64'(sends), 64'd2);

    // backpressure with one dropped byte
    bus.tx_ready = 1'b0;
    exp_q.push_back(seq(8'h11));
    put_frame(8'h11);
    d0 = drops;
    put_byte(8'h5A);
    check("bp_pending", 64'(bus.pending), 64'd1);
    idle(3);
    check("bp_drop", 64'(drops - d0), 64'd1);
    check("bp_nosend", 64'(sends), 64'd2);
    bus.tx_ready = 1'b1;
    idle(4);
    check("bp_sends", 64'(sends), 64'd3);
    check("bp_idle", 64'(bus.pending), 64'd0);

    // ack handshake: second frame waits for a ready toggle
    toggle_ready();
    exp_q.push_back(seq(8'h21));
    put_frame(8'h21);
    idle(3);
    exp_q.push_back(seq(8'h61));
    put_frame(8'h61);
    idle(10);
    check("ack_one_send", 64'(sends), 64'd4);
    check("ack_pending", 64'(bus.pending), 64'd1);
    toggle_ready();
    idle(4);
    check("ack_second", 64'(sends), 64'd5);

    // byte coinciding with the transfer cycle
    bus.tx_ready = 1'b0;
    exp_q.push_back(seq(8'h31));
    put_frame(8'h31);
    idle(2);
    check("co_pending", 64'(bus.pending), 64'd1);
    d0 = drops;
    bus.tx_ready = 1'b1;
    exp_q.push_back(seq(8'h77));
    put_frame(8'h77);
    idle(3);
    check("co_nodrop", 64'(drops - d0), 64'd0);
    check("co_sends", 64'(sends), 64'd6);
    toggle_ready();
    idle(4);
    check("co_second", 64'(sends), 64'd7);

    // asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) put_byte(8'(8'h41 + 8'(i)));
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_data", bus.data, 64'd0);
    check("mr_send", 64'(bus.send), 64'd0);
    check("mr_pending", 64'(bus.pending), 64'd0);
    check("mr_dropped", 64'(bus.dropped), 64'd0);
    idle(2);
    reset_n = 1'b1;
    t0 = cyc + DB - 1;
    exp_q.push_back(seq(8'h51));
    put_frame(8'h51);
    idle(6);
    check("mr_sends", 64'(sends), 64'd8);
    check("mr_latency", 64'(send_cyc - t0), 64'd2);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_payload_collector.md
UART_PAYLOAD_COLLECTOR -- requirements
Module: uart_payload_collector

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8: payload width in bytes, legal range 1..64.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 100000: clk cycles without a byte before a partial frame is flushed; 0 disables flushing.
REQ-003 SHALL have parameter PAD_BYTE, default 8'h00: value used to fill unreceived bytes on flush.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_data, input, 8: byte from the UART receiver.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe marking rx_data valid.
REQ-008 SHALL have port tx_ready, input, 1: high while the downstream UDP transmitter is idle.
REQ-009 SHALL have port data, output, 8*DATA_BYTES: frame presented to the transmitter.
REQ-010 SHALL have port send, output, 1: one-cycle pulse requesting transmission of data.
REQ-011 SHALL have port pending, output, 1: high while a complete frame waits for the transmitter.
REQ-012 SHALL have port dropped, output, 1: one-cycle pulse when an incoming byte is discarded.

Function
REQ-013 SHALL store received bytes in a fill buffer that is separate from the data output register.
- First byte of a frame goes to bits [8*DATA_BYTES-1 -: 8]; each later byte goes to the next lower byte lane.
REQ-014 SHALL keep a byte count of width $clog2(DATA_BYTES+1), starting at 0.
- Each accepted rx_valid increments the count.
REQ-015 SHALL use states FILL and PEND; reset state is FILL.
REQ-016 SHALL move FILL->PEND on the clock edge that accepts the byte making count equal DATA_BYTES.
REQ-017 SHALL move FILL->PEND on an idle-timeout flush, defined as all of:
- IDLE_TIMEOUT>0;
- count>0;
- IDLE_TIMEOUT consecutive cycles without rx_valid.
On flush, lanes not yet written are set to PAD_BYTE.
REQ-018 SHALL, in PEND, transfer the frame when tx_ready=1 and ack_wait=0, all in one cycle:
- copy the fill buffer to data;
- assert send for that cycle;
- clear count and set ack_wait;
- return to FILL.
REQ-019 SHALL clear ack_wait on any cycle where tx_ready=0.
- Consequence: no second send is issued until the transmitter has visibly gone busy and then returned ready.
REQ-020 SHALL, in PEND, discard any rx_valid byte and pulse dropped in the same cycle.
REQ-021 SHALL accept an rx_valid byte that coincides with the PEND->FILL transfer cycle as lane 0 of the next frame, with no drop.
REQ-022 SHALL change data only in send cycles, holding it stable between sends.
REQ-023 SHALL assert send exactly 2 cycles after the rx_valid that completes a frame, provided tx_ready=1 and ack_wait=0.
REQ-024 SHALL drive pending=1 exactly while state is PEND.
REQ-025 SHALL use an idle timer of width $clog2(IDLE_TIMEOUT+1) that saturates and is cleared by rx_valid and by each transfer.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force the following, discarding any partial or pending frame:
- data=0, send=0, pending=0, dropped=0;
- count=0, timer=0, ack_wait=0;
- state=FILL.
REQ-027 SHALL release reset synchronously to clk and accept an rx_valid on the first cycle after release.

Structure
REQ-028 SHALL take its state enum typedef and the PAD_BYTE default constant from a shared package uart_payload_pkg.
REQ-029 SHALL be a single module with no sub-modules.
REQ-030 SHALL be instantiated between uart_receive and ethernet_udp_transmit, with these connections:
- rx_data <- uart_receive.data, rx_valid <- uart_receive.ready;
- tx_ready <- ethernet_udp_transmit.ready;
- data -> ethernet_udp_transmit.data, send -> ethernet_udp_transmit.send.

Verification
REQ-031 SHALL check full frame: bytes 01..08 with tx_ready=1 -> send pulse 2 cycles after byte 08; data=64'h0102030405060708.
REQ-032 SHALL check flush: IDLE_TIMEOUT=16, bytes AA,BB then idle -> send after the timeout; data=64'hAABB000000000000.
REQ-033 SHALL check backpressure: tx_ready=0, 8 bytes then byte 5A -> pending=1, dropped pulses once, no send; tx_ready=1 -> one send, 5A absent from data.
REQ-034 SHALL check ack handshake: tx_ready held 1 for two consecutive frames -> exactly one send until tx_ready drops low and returns high.
REQ-035 SHALL check coincident byte: rx_valid=77 in the transfer cycle -> no drop; the next frame begins with 77.
REQ-036 SHALL check mid-reset: reset_n=0 after 5 bytes -> all outputs 0 immediately; after release, 8 new bytes -> data holds only the new bytes.
